// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and status bundle between the command register and ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic       decoder_inhibit;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_error, decoder_inhibit
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_error, decoder_inhibit
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-collector pull-low enables.
// Define PS2_TX_RESEND_EN to retry a NACKed or timed-out frame up to MAX_RETRY times.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES      = 5000,
  parameter int unsigned REQ_TIMEOUT_CYCLES  = 750000,
  parameter int unsigned XFER_TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned MAX_RETRY           = 2
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_async,
  input  logic         ps2_data_async,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int unsigned TimerMax = (INHIBIT_CYCLES > REQ_TIMEOUT_CYCLES) ?
                                     INHIBIT_CYCLES : REQ_TIMEOUT_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam int unsigned XferW    = $clog2(XFER_TIMEOUT_CYCLES + 1);

  localparam logic [TimerW-1:0] InhLast  = TimerW'(INHIBIT_CYCLES - 1);
  localparam logic [TimerW-1:0] ReqLast  = TimerW'(REQ_TIMEOUT_CYCLES - 1);
  localparam logic [XferW-1:0]  XferLast = XferW'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [XferW-1:0]  XferMax  = XferW'(XFER_TIMEOUT_CYCLES);

  if (SYNC_STAGES < 2 || INHIBIT_CYCLES == 0 || REQ_TIMEOUT_CYCLES == 0 ||
      XFER_TIMEOUT_CYCLES == 0 || MAX_RETRY > 255) begin : g_param_check
    $error("ps2_host_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {
    StIdle, StInhibit, StReq, StData, StAck, StWaitIdle, StDone, StError
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   sync_clk, sync_data, clk_fall;
  logic [9:0]             shift_q;
  logic [3:0]             idx_q;
  logic [TimerW-1:0]      timer_q, timer_lim;
  logic [XferW-1:0]       xfer_q;
  logic                   data_low_q;
  logic                   accept, fail;

  assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
  assign sync_data = data_sync_q[SYNC_STAGES-1];
  assign clk_fall  = clk_prev_q & ~sync_clk;
  assign accept    = (state_q == StIdle) & bus.tx_valid;

  // Idle PS/2 lines sit high, so the chain resets to 1 to avoid a phantom falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_async};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_async};
      clk_prev_q  <= sync_clk;
    end
  end

`ifdef PS2_TX_RESEND_EN
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RetryW-1:0] retry_q;
  logic              can_retry;

  assign can_retry = retry_q < RetryW'(MAX_RETRY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_q <= '0;
    end else if (accept) begin
      retry_q <= '0;
    end else if (fail && can_retry) begin
      retry_q <= retry_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fail    = 1'b0;
    unique case (state_q)
      StIdle:    if (bus.tx_valid) state_d = StInhibit;
      StInhibit: if (timer_q == InhLast) state_d = StReq;
      StReq: begin
        if (clk_fall) state_d = StData;
        else if (timer_q == ReqLast) fail = 1'b1;
      end
      StData: begin
        if (xfer_q == XferLast) fail = 1'b1;
        else if (clk_fall && idx_q == 4'd9) state_d = StAck;
      end
      StAck: begin
        if (xfer_q == XferLast) fail = 1'b1;
        else if (clk_fall) begin
          if (sync_data) fail = 1'b1;
          else state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (xfer_q == XferLast) fail = 1'b1;
        else if (sync_clk && sync_data) state_d = StDone;
      end
      StDone, StError: state_d = StIdle;
      default:         state_d = StIdle;
    endcase
    if (fail) begin
`ifdef PS2_TX_RESEND_EN
      state_d = can_retry ? StInhibit : StError;
`else
      state_d = StError;
`endif
    end
  end

  always_comb begin
    bus.tx_ready        = (state_q == StIdle);
    bus.busy            = (state_q != StIdle);
    bus.decoder_inhibit = (state_q != StIdle);
    bus.tx_done         = (state_q == StDone);
    bus.tx_error        = (state_q == StError);
    ps2_clk_oe          = (state_q == StInhibit);
    ps2_data_oe         = data_low_q & (state_q inside {StReq, StData, StAck});
  end

  assign timer_lim = (state_q == StInhibit) ? TimerW'(INHIBIT_CYCLES) :
                     (state_q == StReq)     ? TimerW'(REQ_TIMEOUT_CYCLES) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      xfer_q     <= '0;
      data_low_q <= 1'b0;
    end else begin
      if (state_d != state_q) timer_q <= '0;
      else if (timer_q != timer_lim) timer_q <= timer_q + 1'b1;

      if (state_q == StReq && state_d == StData) begin
        xfer_q <= '0;
      end else if ((state_q inside {StData, StAck, StWaitIdle}) && xfer_q != XferMax) begin
        xfer_q <= xfer_q + 1'b1;
      end

      if (accept) shift_q <= {1'b1, ~^bus.tx_data, bus.tx_data};

      // Start bit goes out in the same cycle the clock line is released.
      if (state_q == StInhibit && state_d == StReq) data_low_q <= 1'b1;

      if (state_q == StReq && state_d == StData) begin
        data_low_q <= ~shift_q[0];
        idx_q      <= 4'd1;
      end else if (state_q == StData && clk_fall) begin
        data_low_q <= ~shift_q[idx_q];
        idx_q      <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the send-side counterpart of the on-board PS/2 keyboard decoder.
- Sends one command byte to the keyboard, e.g. 0xED LED set, 0xFF reset, 0xF4 enable.
- Uses open-collector signalling: emits active-high pull-low enables for an external tri-state pad, and observes the resynchronized line levels.
- Sits beside the decoder on CLOCK_50, fed from a bus-mapped command register.

Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit time (100 us at 50 MHz).
- REQ_TIMEOUT_CYCLES, 750000: max wait for the first device clock falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, 100000: max time from the first falling edge to the ACK (2 ms).
- SYNC_STAGES, 2: synchronizer depth on ps2_clk_async and ps2_data_async; legal values are 2 and above.
- MAX_RETRY, 2: automatic retries. Used only with PS2_TX_RESEND_EN.

Ports:
- clk, input, 1: system clock (CLOCK_50).
- reset, input, 1: asynchronous, active-high reset.
- tx_data, input, 8: command byte.
- tx_valid, input, 1: request. Accepted in the cycle where tx_valid and tx_ready are both 1.
- tx_ready, output, 1: 1 only in IDLE.
- ps2_clk_async, input, 1: raw PS/2 clock line level.
- ps2_data_async, input, 1: raw PS/2 data line level.
- ps2_clk_oe, output, 1: 1 pulls the PS/2 clock line low.
- ps2_data_oe, output, 1: 1 pulls the PS/2 data line low.
- busy, output, 1: 1 in every state except IDLE.
- tx_done, output, 1: 1-cycle pulse on ACK received and lines idle.
- tx_error, output, 1: 1-cycle pulse on NACK or timeout.
- decoder_inhibit, output, 1: equals busy. The receiver ignores frames while it is high.

Behaviour:
- Reset (async, immediate, including mid-frame): state IDLE, both oe=0 (lines released), tx_ready=1, busy=0, tx_done=0, tx_error=0, all counters 0.
- Line inputs go through a SYNC_STAGES flop chain. A falling edge is detected as sync_clk previous=1 and current=0, one cycle after the synchronizer output.
- Shift register is 10 bits, LSB first: tx_data[7:0], odd parity (~^tx_data), stop bit 1. It is latched at accept.
- IDLE:
  - On accept, go to INHIBIT, set clk_oe=1, load the counter.
  - tx_valid while not ready is ignored; there is no queue.
- INHIBIT:
  - Hold clk_oe=1 for INHIBIT_CYCLES cycles.
  - Then set data_oe=1 (start bit 0), and in the same cycle release clk_oe. Go to REQ.
- REQ:
  - Wait for a falling edge.
  - On the edge: data_oe = ~bit0, bit index 1, go to DATA, start the xfer counter.
  - If REQ_TIMEOUT_CYCLES elapses, go to ERROR.
- DATA:
  - On each falling edge, drive data_oe = ~shift[idx] and increment idx.
  - Edges 1-8 drive data bits, edge 9 drives parity, edge 10 drives the stop bit (data_oe=0, released). After edge 10, go to ACK.
  - Data changes only on falling edges; the device samples on rising edges.
- ACK:
  - On the 11th falling edge, sample sync_data. 0 goes to WAIT_IDLE; 1 (NACK) goes to ERROR.
- WAIT_IDLE:
  - Wait until sync_clk=1 and sync_data=1 in the same cycle, then go to DONE.
- DONE: tx_done=1 for one cycle, then IDLE.
- ERROR:
  - Release both oe, tx_error=1 for one cycle, then IDLE.
- The xfer counter runs in DATA, ACK and WAIT_IDLE. Reaching XFER_TIMEOUT_CYCLES from any of these goes to ERROR.
- tx_ready returns to 1 the cycle after tx_done or tx_error. Back-to-back commands are therefore allowed.
- Counters saturate at their limit; there is no wrap-around.
- Glitch filtering beyond the synchronizer is not required.

Optional Feature:
- Macro: PS2_TX_RESEND_EN.
- Defined:
  - On NACK or timeout, if the retry count is below MAX_RETRY, increment it and re-enter INHIBIT with the latched byte; tx_error stays 0.
  - tx_error pulses only after MAX_RETRY retries have failed.
  - The retry count clears at accept.
- Undefined: the first NACK or timeout pulses tx_error; there is no retry logic.

Test Plan (bench uses INHIBIT_CYCLES=50, REQ_TIMEOUT_CYCLES=2000, XFER_TIMEOUT_CYCLES=5000; device model clocks at 200-cycle period):
- Send 0xED with the device ACKing:
  - clk_oe high for exactly 50 cycles, then start bit 0.
  - Device samples 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; tx_ready returns to 1.
- Send 0x01: device samples parity 0. Send 0x00: device samples parity 1. Both complete with tx_done.
- Device holds data high at the ACK edge (NACK): tx_error pulses once, both oe=0, no tx_done. With PS2_TX_RESEND_EN, the frame is sent 3 times and then tx_error pulses.
- Device never clocks: tx_error pulses 2000 cycles after entering REQ, and ps2_data_oe is released.
- Assert reset after falling edge 4: both oe drop asynchronously, and the next cycle shows IDLE with tx_ready=1. A fresh 0xF4 then completes with tx_done.
- tx_valid held with 0xAA during a busy 0xFF transfer: only 0xFF is sent. 0xAA is accepted in the first IDLE cycle after tx_done.
